// File: rtl/pmem_types_pkg.sv
// pmem_types_pkg
// Shared types and sizing constants for the physical-memory responder.
// Holds the responder state enum, the default line/beat widths, the number
// of beats per line and the address-field widths derived from a 32-byte line.
package pmem_types_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_RESP
  } state_e;

  localparam int DEF_LINE_WIDTH   = 256;
  localparam int DEF_BEAT_WIDTH   = 64;
  localparam int BEATS            = DEF_LINE_WIDTH / DEF_BEAT_WIDTH;

  // A line is 32 bytes, so the low 5 address bits select a byte inside it and
  // are not part of the line address.
  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEAT_IDX_BITS    = 2;
  localparam int MEM_ADDR_WIDTH   = 32 - LINE_OFFSET_BITS + BEAT_IDX_BITS;

endpackage

// File: rtl/pmem_responder.sv
// pmem_responder
// Serves whole cache-line read/write requests against a narrower synchronous
// backing memory, inserting a programmable number of wait cycles before the
// beats are moved.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   pmem_read/write     line requests, held by the initiator until pmem_resp
//   pmem_address        line address (low 5 bits ignored)
//   pmem_wdata          write line
//   pmem_rdata          assembled read line (registered, held between reads)
//   pmem_resp           one-cycle completion pulse
//   mem_addr/we/wdata   backing memory word address, write enable, write word
//   mem_rdata           backing memory read word, valid one cycle after mem_addr
module pmem_responder
  import pmem_types_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pmem_read,
  input  logic                      pmem_write,
  input  logic [31:0]               pmem_address,
  input  logic [LINE_WIDTH-1:0]     pmem_wdata,
  output logic [LINE_WIDTH-1:0]     pmem_rdata,
  output logic                      pmem_resp,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_we,
  output logic [BEAT_WIDTH-1:0]     mem_wdata,
  input  logic [BEAT_WIDTH-1:0]     mem_rdata
);

  localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam int LADDR_W = 32 - LINE_OFFSET_BITS;

  // The wait counter is loaded with LATENCY-1 so that S_WAIT spans exactly
  // LATENCY cycles; with no latency S_WAIT is skipped and the value is unused.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e                    state_q,   state_d;
  logic [3:0]                waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]          beatCnt_q, beatCnt_d;
  logic                      isWrite_q, isWrite_d;
  logic [LADDR_W-1:0]        addr_q,    addr_d;
  logic [LINE_WIDTH-1:0]     wline_q,   wline_d;
  logic [LINE_WIDTH-1:0]     rdata_q,   rdata_d;
  logic [CNT_W-1:0]          lastBeat;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^pmem_address[LINE_OFFSET_BITS-1:0];

  // Reads need one extra transfer cycle because the last word returns one
  // cycle after its address was presented.
  assign lastBeat = isWrite_q ? CNT_W'(NBEATS - 1) : CNT_W'(NBEATS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      waitCnt_q <= '0;
      beatCnt_q <= '0;
      isWrite_q <= 1'b0;
      addr_q    <= '0;
      wline_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      beatCnt_q <= beatCnt_d;
      isWrite_q <= isWrite_d;
      addr_q    <= addr_d;
      wline_q   <= wline_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    beatCnt_d = beatCnt_q;
    isWrite_d = isWrite_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        // A simultaneous read and write is served as the write.
        if (pmem_read || pmem_write) begin
          isWrite_d = pmem_write;
          addr_d    = pmem_address[31:LINE_OFFSET_BITS];
          if (pmem_write) begin
            wline_d = pmem_wdata;
          end
          beatCnt_d = '0;
          waitCnt_d = WAIT_INIT;
          state_d   = (LATENCY > 0) ? S_WAIT : S_XFER;
        end
      end

      S_WAIT: begin
        if (waitCnt_q == '0) begin
          state_d = S_XFER;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end

      S_XFER: begin
        // The word arriving now belongs to the address issued last cycle.
        if (!isWrite_q && (beatCnt_q != '0)) begin
          rdata_d[(int'(beatCnt_q) - 1) * BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
        end
        if (beatCnt_q == lastBeat) begin
          beatCnt_d = '0;
          state_d   = S_RESP;
        end else begin
          beatCnt_d = beatCnt_q + 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pmem_resp  = (state_q == S_RESP);
  assign pmem_rdata = rdata_q;
  assign mem_we     = (state_q == S_XFER) && isWrite_q;
  assign mem_addr   = {addr_q, beatCnt_q[BEAT_IDX_BITS-1:0]};
  assign mem_wdata  = wline_q[int'(beatCnt_q[BEAT_IDX_BITS-1:0]) * BEAT_WIDTH +: BEAT_WIDTH];

endmodule
